// File: rtl/data_mem_sys.sv
// Data-side memory subsystem: word SRAM plus memory-mapped machine timer behind one
// req/gnt/rvalid port, with a fixed-latency in-order response pipeline.
module data_mem_sys #(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 1,
    parameter int          STALL_EVERY = 0,
    parameter logic [31:0] TIMER_ADDR  = 32'h0001_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        timer_irq_o
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] MEM_BYTES = 32'(DEPTH * 4);
    localparam int          SCW       = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;

    logic          accept;
    logic [31:0]   mem_off;
    logic          mem_hit;
    logic          tmr_hit;
    logic [AW-1:0] mem_idx;
    logic [31:0]   wmask;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic          irq_q;

    logic [31:0]   mem_q [DEPTH];

    logic [LATENCY-1:0] pv_q;
    logic [LATENCY-1:0] perr_q;
    logic [31:0]        prd_q [LATENCY];

    // Grant back-pressure: every STALL_EVERY-th cycle with req high is refused.
    generate
        if (STALL_EVERY == 0) begin : g_nostall
            assign data_gnt_o = data_req_i;
        end else begin : g_stall
            logic [SCW-1:0] stall_cnt_q, stall_cnt_d;
            logic           stall_hit;

            assign stall_hit  = (stall_cnt_q == SCW'(STALL_EVERY - 1));
            assign data_gnt_o = data_req_i & ~stall_hit;

            always_comb begin
                stall_cnt_d = stall_cnt_q;
                if (data_req_i) begin
                    stall_cnt_d = stall_hit ? '0 : stall_cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    stall_cnt_q <= '0;
                end else begin
                    stall_cnt_q <= stall_cnt_d;
                end
            end
        end
    endgenerate

    assign accept  = data_req_i & data_gnt_o;
    assign mem_off = data_addr_i - BASE_ADDR;
    assign mem_hit = (data_addr_i >= BASE_ADDR) && (mem_off < MEM_BYTES);
    assign tmr_hit = !mem_hit && (data_addr_i[31:4] == TIMER_ADDR[31:4]);
    assign mem_idx = mem_off[AW+1:2];
    assign wmask   = {{8{data_be_i[3]}}, {8{data_be_i[2]}},
                      {8{data_be_i[1]}}, {8{data_be_i[0]}}};

    // Memory contents are deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (accept && data_we_i && mem_hit) begin
            for (int k = 0; k < 4; k++) begin
                if (data_be_i[k]) begin
                    mem_q[mem_idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
                end
            end
        end
    end

    // A write to an mtime half replaces the freshly incremented bytes it enables.
    always_comb begin
        mtime_d    = mtime_q + 64'd1;
        mtimecmp_d = mtimecmp_q;
        if (accept && data_we_i && tmr_hit) begin
            case (data_addr_i[3:2])
                2'd0: mtime_d[31:0]     = (mtime_d[31:0] & ~wmask) | (data_wdata_i & wmask);
                2'd1: mtime_d[63:32]    = (mtime_d[63:32] & ~wmask) | (data_wdata_i & wmask);
                2'd2: mtimecmp_d[31:0]  = (mtimecmp_q[31:0] & ~wmask) | (data_wdata_i & wmask);
                default: mtimecmp_d[63:32] = (mtimecmp_q[63:32] & ~wmask) | (data_wdata_i & wmask);
            endcase
        end
    end

    always_comb begin
        rsp_rdata = '0;
        rsp_err   = !mem_hit && !tmr_hit;
        if (!data_we_i) begin
            if (mem_hit) begin
                rsp_rdata = mem_q[mem_idx];
            end else if (tmr_hit) begin
                case (data_addr_i[3:2])
                    2'd0:    rsp_rdata = mtime_q[31:0];
                    2'd1:    rsp_rdata = mtime_q[63:32];
                    2'd2:    rsp_rdata = mtimecmp_q[31:0];
                    default: rsp_rdata = mtimecmp_q[63:32];
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            irq_q      <= (mtime_d >= mtimecmp_d);
        end
    end

    // Empty slots carry zero data so the outputs stay quiet between responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pv_q   <= '0;
            perr_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                prd_q[i] <= '0;
            end
        end else begin
            pv_q[0]   <= accept;
            perr_q[0] <= accept & rsp_err;
            prd_q[0]  <= accept ? rsp_rdata : 32'd0;
            for (int i = 1; i < LATENCY; i++) begin
                pv_q[i]   <= pv_q[i-1];
                perr_q[i] <= perr_q[i-1];
                prd_q[i]  <= prd_q[i-1];
            end
        end
    end

    assign data_rvalid_o = pv_q[LATENCY-1];
    assign data_rdata_o  = prd_q[LATENCY-1];
    assign data_err_o    = perr_q[LATENCY-1];
    assign timer_irq_o   = irq_q;

endmodule

// File: tb/tb_data_mem_sys.sv
// Randomised bench for data_mem_sys against a transaction-level model of memory,
// timer, grant pattern and response timing.
module tb_data_mem_sys;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          LAT   = 3;
    localparam int          STALL = 3;
    localparam logic [31:0] TADDR = 32'h0001_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        data_req_i;
    logic        data_gnt_o;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        timer_irq_o;

    data_mem_sys #(
        .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT),
        .STALL_EVERY(STALL), .TIMER_ADDR(TADDR)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o),
        .data_addr_i(data_addr_i), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .data_err_o(data_err_o), .timer_irq_o(timer_irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } rsp_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          req_cnt  = 0;
    logic [63:0] mtime_m;
    logic [63:0] cmp_m;
    logic [31:0] mem_m [DEPTH];
    rsp_t        exp_q [$];
    logic        acc_s;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = wd[8*k +: 8];
        return r;
    endfunction

    // One clock cycle: drive at negedge, check grant, model the edge, check outputs.
    task automatic step(input logic req, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd, output logic acc);
        logic        exp_gnt, exp_v;
        logic [31:0] off;
        logic [63:0] nt, nc;
        logic [1:0]  sel;
        rsp_t        r;
        data_req_i = req; data_we_i = we; data_addr_i = addr;
        data_be_i = be; data_wdata_i = wd;
        #1;
        exp_gnt = req && (STALL == 0 || (req_cnt % STALL) != STALL - 1);
        check("gnt", data_gnt_o, exp_gnt);
        @(posedge clk_i);
        acc = req && exp_gnt;
        cyc++;
        if (req) req_cnt++;
        nt = mtime_m + 64'd1;
        nc = cmp_m;
        if (acc) begin
            r.rdata = '0; r.err = 1'b0; r.due = cyc + LAT - 1;
            off = addr - BASE;
            sel = addr[3:2];
            if (addr >= BASE && off < 32'(DEPTH * 4)) begin
                if (we) mem_m[off / 4] = merge(mem_m[off / 4], wd, be);
                else    r.rdata = mem_m[off / 4];
            end else if ((addr & ~32'hF) == TADDR) begin
                if (we) begin
                    case (sel)
                        2'd0: nt[31:0]  = merge(nt[31:0], wd, be);
                        2'd1: nt[63:32] = merge(nt[63:32], wd, be);
                        2'd2: nc[31:0]  = merge(nc[31:0], wd, be);
                        default: nc[63:32] = merge(nc[63:32], wd, be);
                    endcase
                end else begin
                    case (sel)
                        2'd0: r.rdata = mtime_m[31:0];
                        2'd1: r.rdata = mtime_m[63:32];
                        2'd2: r.rdata = cmp_m[31:0];
                        default: r.rdata = cmp_m[63:32];
                    endcase
                end
            end else begin
                r.err = 1'b1;
            end
            exp_q.push_back(r);
        end
        mtime_m = nt;
        cmp_m   = nc;
        @(negedge clk_i);
        exp_v = (exp_q.size() != 0) && (exp_q[0].due == cyc);
        check("rvalid", data_rvalid_o, exp_v);
        if (exp_v) begin
            check("rdata", data_rdata_o, exp_q[0].rdata);
            check("err", data_err_o, exp_q[0].err);
            void'(exp_q.pop_front());
        end else if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
            void'(exp_q.pop_front());
        end
        check("irq", timer_irq_o, mtime_m >= cmp_m);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 4'd0, 32'd0, a);
    endtask

    // Holds the request until granted, as the core would; bounded retries.
    task automatic xfer(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd);
        logic a;
        a = 1'b0;
        for (int t = 0; t < 8 && !a; t++) step(1'b1, we, addr, be, wd, a);
        if (!a) begin
            n_checks++;
            n_errors++;
            $display("FAIL xfer_timeout: addr %0h never granted", addr);
        end
    endtask

    task automatic do_reset(input int hold);
        rst_ni = 1'b0;
        data_req_i = 1'b0;
        #1;
        check("rst_rvalid", data_rvalid_o, 1'b0);
        check("rst_rdata", data_rdata_o, 32'd0);
        check("rst_err", data_err_o, 1'b0);
        check("rst_irq", timer_irq_o, 1'b0);
        check("rst_gnt", data_gnt_o, 1'b0);
        exp_q.delete();
        req_cnt = 0;
        mtime_m = 64'd0;
        cmp_m   = '1;
        repeat (hold) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0;
        data_req_i = 1'b0; data_we_i = 1'b0; data_addr_i = '0;
        data_be_i = '0; data_wdata_i = '0;
        @(negedge clk_i);
        do_reset(2);

        xfer(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
        xfer(1'b0, 32'h10, 4'hF, 32'h0);
        idle(LAT);

        xfer(1'b1, 32'h20, 4'hF, 32'h1122_3344);
        xfer(1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD);
        xfer(1'b0, 32'h20, 4'h0, 32'h0);
        idle(LAT);
        check("be_merge", mem_m[8], 32'h11BB_33DD);

        for (int w = 0; w < 16; w++) xfer(1'b1, BASE + 32'(4 * w), 4'hF, $urandom);
        xfer(1'b1, BASE + 32'(4 * (DEPTH - 1)), 4'hF, $urandom);
        idle(2);

        for (int w = 0; w < 6; w++) xfer(1'b0, BASE + 32'(4 * w), 4'hF, 32'h0);
        idle(LAT + 1);

        xfer(1'b0, BASE + 32'(4 * DEPTH), 4'hF, 32'h0);
        xfer(1'b1, BASE + 32'(4 * DEPTH), 4'hF, 32'hCAFE_F00D);
        xfer(1'b0, BASE, 4'hF, 32'h0);
        xfer(1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0);
        xfer(1'b0, BASE + 32'(4 * (DEPTH - 1)), 4'hF, 32'h0);
        idle(LAT + 1);

        for (int i = 0; i < 300; i++) begin
            int          k, w;
            logic [31:0] a;
            logic        r;
            k = $urandom_range(0, 9);
            w = $urandom_range(0, 16);
            if (w == 16) w = DEPTH - 1;
            a = BASE + 32'(4 * w);
            case (k)
                0, 1:    step(1'b0, 1'b0, 32'd0, 4'd0, 32'd0, r);
                2, 3, 4: step(1'b1, 1'b1, a, 4'($urandom), $urandom, r);
                5, 6, 7: step(1'b1, 1'b0, a, 4'hF, 32'd0, r);
                8:       step(1'b1, 1'($urandom), BASE + 32'(4 * DEPTH) + 32'(4 * w),
                              4'hF, $urandom, r);
                default: step(1'b1, 1'b0, TADDR + 32'(4 * $urandom_range(0, 3)),
                              4'hF, 32'd0, r);
            endcase
        end
        idle(LAT + 1);

        xfer(1'b0, BASE, 4'hF, 32'h0);
        xfer(1'b0, BASE + 32'h4, 4'hF, 32'h0);
        do_reset(2);
        idle(LAT + 3);
        xfer(1'b0, TADDR, 4'hF, 32'h0);
        xfer(1'b0, BASE + 32'h4, 4'hF, 32'h0);
        idle(LAT + 1);

        do_reset(1);
        xfer(1'b1, TADDR + 32'h8, 4'hF, 32'd100);
        xfer(1'b1, TADDR + 32'hC, 4'hF, 32'd0);
        idle(110);
        check("irq_after_cmp", timer_irq_o, 1'b1);
        xfer(1'b1, TADDR + 32'h8, 4'hF, 32'hFFFF_FFFF);
        idle(2);
        check("irq_dropped", timer_irq_o, 1'b0);

        xfer(1'b1, TADDR + 32'h4, 4'hF, 32'hFFFF_FFFF);
        xfer(1'b1, TADDR, 4'hF, 32'hFFFF_FFFE);
        xfer(1'b0, TADDR, 4'hF, 32'h0);
        xfer(1'b0, TADDR + 32'h4, 4'hF, 32'h0);
        xfer(1'b1, TADDR, 4'b0011, 32'h0000_5A5A);
        xfer(1'b0, TADDR, 4'hF, 32'h0);
        xfer(1'b0, TADDR + 32'h8, 4'hF, 32'h0);
        idle(LAT + 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
